// File: rtl/serial_mod_pkg.sv
// -----------------------------------------------------------------------------
// serial_mod_pkg
// Shared types, limits and helpers for the streaming divisibility checker.
//   serial_mod_state_e : IDLE (no bits since reset/clear), ACTIVE (>= 1 beat)
//   rem_width()        : remainder register width for a given divisor
//   MAX_DIVISOR/MAX_BPC: legal upper bounds checked at elaboration
// Optional feature macro used by the top level: SERIAL_MOD_REM_OUT_EN
// -----------------------------------------------------------------------------
package serial_mod_pkg;

    localparam int MAX_DIVISOR = 255;
    localparam int MAX_BPC     = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } serial_mod_state_e;

    // Width needed to hold any remainder 0..divisor-1. Illegal small divisors
    // still get a 1-bit width so elaboration reaches the range check cleanly.
    function automatic int rem_width(input int divisor);
        if (divisor < 2) begin
            return 1;
        end
        return $clog2(divisor);
    endfunction

endpackage

// File: rtl/serial_mod_checker_mod_step.sv
// -----------------------------------------------------------------------------
// mod_step
// Combinational single-bit remainder update: r' = (2*r + b) mod DIVISOR.
// Because r < DIVISOR, 2r+b < 2*DIVISOR, so one conditional subtract suffices;
// no divider or multiplier is needed.
// Ports:
//   r    in  REM_W  current remainder (must be < DIVISOR)
//   b    in  1      next bit (less significant than everything in r)
//   rnxt out REM_W  updated remainder
// -----------------------------------------------------------------------------
module mod_step
    import serial_mod_pkg::*;
#(
    parameter int DIVISOR = 5,
    localparam int REM_W = rem_width(DIVISOR)
) (
    input  logic [REM_W-1:0] r,
    input  logic             b,
    output logic [REM_W-1:0] rnxt
);

    // One extra bit holds 2r+b, which can reach 2*DIVISOR-1.
    localparam logic [REM_W:0] DIV_EXT = (REM_W+1)'(DIVISOR);

    logic [REM_W:0] t;
    logic [REM_W:0] t_red;

    always_comb begin
        t     = {r, b};
        t_red = t;
        if (t >= DIV_EXT) begin
            t_red = t - DIV_EXT;
        end
        rnxt = t_red[REM_W-1:0];
    end

endmodule

// File: rtl/serial_mod_checker.sv
// -----------------------------------------------------------------------------
// serial_mod_checker
// Streaming divisibility checker. An unbounded unsigned value is shifted in
// MSB-first, BPC bits per accepted beat; after each beat dout reports whether
// the cumulative value is divisible by DIVISOR. Only the remainder is stored.
//
// Flow control: din is consumed on every rising edge where din_valid is high;
// there is no ready, so the block accepts one beat per cycle unconditionally.
// dout_valid pulses for exactly one cycle after each accepted beat.
//
// Ports:
//   clk        in  1      rising-edge clock
//   resetn     in  1      asynchronous active-low reset
//   din_valid  in  1      beat qualifier
//   din        in  BPC    beat bits, din[BPC-1] most significant
//   clear      in  1      synchronous restart (a same-cycle beat starts the
//                         new value)
//   dout       out 1      value mod DIVISOR == 0 and at least one beat taken
//   dout_valid out 1      one-cycle pulse after each accepted beat
//   rem        out REM_W  current remainder (only with SERIAL_MOD_REM_OUT_EN)
//   state      out        FSM state, for observation
//
// Configuration macro: SERIAL_MOD_REM_OUT_EN adds the rem port.
// -----------------------------------------------------------------------------
module serial_mod_checker
    import serial_mod_pkg::*;
#(
    parameter int DIVISOR = 5,
    parameter int BPC     = 1,
    localparam int REM_W  = rem_width(DIVISOR)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              din_valid,
    input  logic [BPC-1:0]    din,
    input  logic              clear,
    output logic              dout,
    output logic              dout_valid,
`ifdef SERIAL_MOD_REM_OUT_EN
    output logic [REM_W-1:0]  rem,
`endif
    output serial_mod_state_e state
);

    // Elaboration-time parameter range checks.
    generate
        if (DIVISOR < 2 || DIVISOR > MAX_DIVISOR) begin : g_bad_divisor
            $error("serial_mod_checker: DIVISOR %0d outside 2..%0d", DIVISOR, MAX_DIVISOR);
        end
        if (BPC < 1 || BPC > MAX_BPC) begin : g_bad_bpc
            $error("serial_mod_checker: BPC %0d outside 1..%0d", BPC, MAX_BPC);
        end
    endgenerate

    logic [REM_W-1:0] r;
    logic [REM_W-1:0] r_base;
    logic [REM_W-1:0] r_next;
    logic [REM_W-1:0] chain [BPC+1];

    // clear restarts the value, so a beat arriving with clear is applied to 0.
    // In IDLE r is already 0; selecting 0 explicitly keeps the intent obvious.
    always_comb begin
        r_base = r;
        if (clear || state == IDLE) begin
            r_base = '0;
        end
    end

    assign chain[0] = r_base;

    // MSB of the beat goes through the first step.
    genvar gi;
    generate
        for (gi = 0; gi < BPC; gi++) begin : g_step
            mod_step #(
                .DIVISOR (DIVISOR)
            ) u_step (
                .r    (chain[gi]),
                .b    (din[BPC-1-gi]),
                .rnxt (chain[gi+1])
            );
        end
    endgenerate

    assign r_next = chain[BPC];

    // FSM, remainder register and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            r          <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= din_valid;
            if (din_valid) begin
                state <= ACTIVE;
                r     <= r_next;
                dout  <= (r_next == '0);
            end else if (clear) begin
                state <= IDLE;
                r     <= '0;
                dout  <= 1'b0;
            end
        end
    end

`ifdef SERIAL_MOD_REM_OUT_EN
    assign rem = r;
`endif

endmodule

// File: tb/tb_serial_mod_checker.sv
module tb_serial_mod_checker;
  import serial_mod_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DUT a: DIVISOR=5, BPC=1
  logic a_valid, a_din, a_clear, a_dout, a_dv;
  serial_mod_state_e a_state;
  // DUT b: DIVISOR=3, BPC=4
  logic b_valid, b_clear, b_dout, b_dv;
  logic [3:0] b_din;
  serial_mod_state_e b_state;
  // DUT c: DIVISOR=7, BPC=8
  logic c_valid, c_clear, c_dout, c_dv;
  logic [7:0] c_din;
  serial_mod_state_e c_state;
`ifdef SERIAL_MOD_REM_OUT_EN
  logic [2:0] a_rem;
  logic [1:0] b_rem;
  logic [2:0] c_rem;
`endif

  serial_mod_checker #(.DIVISOR(5), .BPC(1)) u_a (
    .clk(clk), .resetn(resetn), .din_valid(a_valid), .din(a_din),
    .clear(a_clear), .dout(a_dout), .dout_valid(a_dv),
`ifdef SERIAL_MOD_REM_OUT_EN
    .rem(a_rem),
`endif
    .state(a_state)
  );

  serial_mod_checker #(.DIVISOR(3), .BPC(4)) u_b (
    .clk(clk), .resetn(resetn), .din_valid(b_valid), .din(b_din),
    .clear(b_clear), .dout(b_dout), .dout_valid(b_dv),
`ifdef SERIAL_MOD_REM_OUT_EN
    .rem(b_rem),
`endif
    .state(b_state)
  );

  serial_mod_checker #(.DIVISOR(7), .BPC(8)) u_c (
    .clk(clk), .resetn(resetn), .din_valid(c_valid), .din(c_din),
    .clear(c_clear), .dout(c_dout), .dout_valid(c_dv),
`ifdef SERIAL_MOD_REM_OUT_EN
    .rem(c_rem),
`endif
    .state(c_state)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change #1 after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic d, input logic c);
    a_valid = v; a_din = d; a_clear = c;
    tick();
    a_valid = 1'b0; a_din = 1'b0; a_clear = 1'b0;
  endtask

  initial begin
    logic [0:0] e;
    logic [0:0] bits [4];
    a_valid = 0; a_din = 0; a_clear = 0;
    b_valid = 0; b_din = 0; b_clear = 0;
    c_valid = 0; c_din = 0; c_clear = 0;

    // Reset state
    repeat (3) tick();
    check("rst_dout", a_dout, 0);
    check("rst_dv", a_dv, 0);
    check("rst_state", a_state, IDLE);
    check("rst_state_c", c_state, IDLE);
`ifdef SERIAL_MOD_REM_OUT_EN
    check("rst_rem", a_rem, 0);
`endif
    resetn = 1'b1;

    // No beats after reset: dout stays 0
    repeat (5) tick();
    check("idle_dout_held", a_dout, 0);
    check("idle_state", a_state, IDLE);

    // DIVISOR=5, BPC=1: 1,0,1,0 -> values 1,2,5,10 -> dout 0,0,1,1
    bits[0] = 1; bits[1] = 0; bits[2] = 1; bits[3] = 0;
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, bits[i], 1'b0);
      e = exp_q.pop_front();
      check($sformatf("d5_dout_%0d", i), a_dout, e);
      check($sformatf("d5_dv_%0d", i), a_dv, 1);
    end
`ifdef SERIAL_MOD_REM_OUT_EN
    check("d5_rem", a_rem, 0);
`endif
    tick();
    check("d5_gap_dv", a_dv, 0);
    check("d5_gap_dout", a_dout, 1);

    // Reset then leading 0 beat -> value 0, dout 1
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    drive_a(1'b1, 1'b0, 1'b0);
    check("lead0_dout", a_dout, 1);
    check("lead0_state", a_state, ACTIVE);

    // DIVISOR=3, BPC=4: 0xC (12) -> dout 1 rem 0; 0x1 (193) -> dout 0 rem 1
    b_valid = 1; b_din = 4'hC;
    tick();
    check("d3_b0_dout", b_dout, 1);
    check("d3_b0_dv", b_dv, 1);
`ifdef SERIAL_MOD_REM_OUT_EN
    check("d3_b0_rem", b_rem, 0);
`endif
    b_din = 4'h1;
    tick();
    b_valid = 0; b_din = 0;
    check("d3_b1_dout", b_dout, 0);
`ifdef SERIAL_MOD_REM_OUT_EN
    check("d3_b1_rem", b_rem, 1);
`endif

    // DIVISOR=7, BPC=8: 0xFF = 255 -> rem 3, dout 0; then 5 idle cycles
    c_valid = 1; c_din = 8'hFF;
    tick();
    c_valid = 0; c_din = 0;
    check("d7_dout", c_dout, 0);
    check("d7_dv", c_dv, 1);
`ifdef SERIAL_MOD_REM_OUT_EN
    check("d7_rem", c_rem, 3);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("d7_gap_dv_%0d", i), c_dv, 0);
`ifdef SERIAL_MOD_REM_OUT_EN
      check($sformatf("d7_gap_rem_%0d", i), c_rem, 3);
`endif
    end
    check("d7_gap_dout", c_dout, 0);

    // clear alone: back to IDLE, dout 0 (was 1 from leading 0)
    drive_a(1'b0, 1'b0, 1'b1);
    check("clr_dout", a_dout, 0);
    check("clr_dv", a_dv, 0);
    check("clr_state", a_state, IDLE);

    // stream 1,1 (value 3), then clear+beat 0 -> new value 0
    drive_a(1'b1, 1'b1, 1'b0);
    drive_a(1'b1, 1'b1, 1'b0);
    check("s11_dout", a_dout, 0);
`ifdef SERIAL_MOD_REM_OUT_EN
    check("s11_rem", a_rem, 3);
`endif
    drive_a(1'b1, 1'b0, 1'b1);
    check("clrbeat_dout", a_dout, 1);
    check("clrbeat_dv", a_dv, 1);
    check("clrbeat_state", a_state, ACTIVE);
`ifdef SERIAL_MOD_REM_OUT_EN
    check("clrbeat_rem", a_rem, 0);
`endif

    // clear + beat 1 -> value 1 (not 0*2+1 on old value path confusion)
    drive_a(1'b1, 1'b1, 1'b1);
    check("clrbeat1_dout", a_dout, 0);
`ifdef SERIAL_MOD_REM_OUT_EN
    check("clrbeat1_rem", a_rem, 1);
`endif

    // Async reset mid-cycle: stream value 5 (dout 1, dv 1), then reset
    drive_a(1'b1, 1'b0, 1'b1);   // restart at 0
    drive_a(1'b1, 1'b1, 1'b0);   // 1
    drive_a(1'b1, 1'b0, 1'b0);   // 2
    a_valid = 1'b1; a_din = 1'b1; // 5
    tick();
    check("pre_arst_dout", a_dout, 1);
    check("pre_arst_dv", a_dv, 1);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_dout", a_dout, 0);
    check("arst_dv", a_dv, 0);
    check("arst_state", a_state, IDLE);
`ifdef SERIAL_MOD_REM_OUT_EN
    check("arst_rem", a_rem, 0);
`endif
    #1;
    resetn = 1'b1;
    // a_valid/a_din still 1: next edge takes bit 1 as a fresh value
    tick();
    a_valid = 1'b0; a_din = 1'b0;
    check("post_arst_dout", a_dout, 0);
    check("post_arst_state", a_state, ACTIVE);
`ifdef SERIAL_MOD_REM_OUT_EN
    check("post_arst_rem", a_rem, 1);
`endif

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
